// File: rtl/hack_cpu_seq.sv
// Multi-cycle Hack CPU sequencer: fetches, decodes and executes A/C instructions
// over request/ack handshakes, driving the Hack ALU instantiated below.

module ALU (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] xz, xn, yz, yn, fo;

  always_comb begin
    xz  = zx ? 16'h0000 : x;
    xn  = nx ? ~xz : xz;
    yz  = zy ? 16'h0000 : y;
    yn  = ny ? ~yz : yz;
    fo  = f ? (xn + yn) : (xn & yn);
    out = no ? ~fo : fo;
  end

  assign zr = (out == 16'h0000);
  assign ng = out[15];

endmodule

module hack_cpu_seq (
  input  logic        clk,
  input  logic        reset_n,
  output logic        instr_req,
  output logic [14:0] instr_addr,
  input  logic        instr_valid,
  input  logic [15:0] instr_data,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        retire,
  output logic [14:0] pc,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MRD    = 3'd2,
    EXEC   = 3'd3,
    MWR    = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic [15:0] m_reg;
  logic [15:0] alu_y;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic        req_nxt, rd_nxt, wr_nxt;
  logic        is_c, use_m, dest_a, dest_d, dest_m, take;
  logic [14:0] pc_inc;

  assign is_c   = ir[15];
  assign use_m  = ir[12];
  assign dest_a = ir[5];
  assign dest_d = ir[4];
  assign dest_m = ir[3];
  assign pc_inc = pc + 15'd1;
  assign alu_y  = use_m ? m_reg : a_reg;
  assign take   = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);

  assign instr_addr = pc;

  ALU u_alu (
    .x   (d_reg),
    .y   (alu_y),
    .zx  (ir[11]),
    .nx  (ir[10]),
    .zy  (ir[9]),
    .ny  (ir[8]),
    .f   (ir[7]),
    .no  (ir[6]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  // Request lines are flopped from the next state so they are glitch-free and
  // high for exactly the cycles spent in the consuming state.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        if (instr_req && instr_valid) state_nxt = DECODE;
      end
      DECODE: begin
        if (!is_c) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end else if (use_m) begin
          state_nxt = MRD;
        end else begin
          state_nxt = EXEC;
        end
      end
      MRD: begin
        if (mem_ack) state_nxt = EXEC;
      end
      EXEC: begin
        if (dest_m) begin
          state_nxt = MWR;
        end else begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      MWR: begin
        if (mem_ack) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
    req_nxt = (state_nxt == FETCH);
    rd_nxt  = (state_nxt == MRD);
    wr_nxt  = (state_nxt == MWR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_req <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      instr_req <= req_nxt;
      mem_rd    <= rd_nxt;
      mem_wr    <= wr_nxt;
    end
  end

  // mem_addr/mem_wdata double as the latched store address and data; the jump
  // target and store address both use A as it was before this EXEC edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= 15'd0;
      a_reg     <= 16'h0000;
      d_reg     <= 16'h0000;
      ir        <= 16'h0000;
      m_reg     <= 16'h0000;
      mem_addr  <= 15'd0;
      mem_wdata <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (instr_req && instr_valid) ir <= instr_data;
        end
        DECODE: begin
          if (!is_c) begin
            a_reg <= {1'b0, ir[14:0]};
            pc    <= pc_inc;
          end else if (use_m) begin
            mem_addr <= a_reg[14:0];
          end
        end
        MRD: begin
          if (mem_ack) begin
            m_reg    <= mem_rdata;
            mem_addr <= 15'd0;
          end
        end
        EXEC: begin
          if (dest_a) a_reg <= alu_out;
          if (dest_d) d_reg <= alu_out;
          pc <= take ? a_reg[14:0] : pc_inc;
          if (dest_m) begin
            mem_addr  <= a_reg[14:0];
            mem_wdata <= alu_out;
          end
        end
        MWR: begin
          if (mem_ack) begin
            mem_addr  <= 15'd0;
            mem_wdata <= 16'h0000;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
